// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared I2C field widths and arbiter state encoding
package i2c_pkg;

  localparam int I2C_ADDR_W = 7;
  localparam int I2C_REG_W  = 8;
  localparam int I2C_DATA_W = 32;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } arb_state_e;

endpackage

// File: rtl/i2c_arbiter_if.sv
// rtl/i2c_arbiter_if.sv - requester and i2c_master signals seen by the arbiter
interface i2c_arbiter_if
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 4
) ();

  logic [NUM_REQ-1:0]            req;
  logic [I2C_ADDR_W*NUM_REQ-1:0] req_slave_address;
  logic [NUM_REQ-1:0]            req_read_write;
  logic [I2C_REG_W*NUM_REQ-1:0]  req_register_address;
  logic [I2C_DATA_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]            grant;
  logic [NUM_REQ-1:0]            done;
  logic [NUM_REQ-1:0]            error;
  logic [I2C_DATA_W-1:0]         rd_data;
  logic                          busy;

  logic                          m_en;
  logic [I2C_ADDR_W-1:0]         m_slave_address;
  logic                          m_read_write;
  logic [I2C_REG_W-1:0]          m_register_address;
  logic [I2C_DATA_W-1:0]         m_data;
  logic [I2C_DATA_W-1:0]         m_data_in;
  logic                          m_done;

  // Arbiter side
  modport slave (
    input  req, req_slave_address, req_read_write, req_register_address, req_data,
    input  m_data_in, m_done,
    output grant, done, error, rd_data, busy,
    output m_en, m_slave_address, m_read_write, m_register_address, m_data
  );

  // Requesters plus i2c_master side
  modport master (
    output req, req_slave_address, req_read_write, req_register_address, req_data,
    output m_data_in, m_done,
    input  grant, done, error, rd_data, busy,
    input  m_en, m_slave_address, m_read_write, m_register_address, m_data
  );

endinterface

// File: rtl/i2c_rr_picker.sv
// rtl/i2c_rr_picker.sv - combinational round-robin pick: first set req after ptr, with wrap
module i2c_rr_picker #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  grant_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);

  logic found;
  int   j;

  // k runs 1..N so the last candidate examined is ptr itself
  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    found   = 1'b0;
    j       = 0;
    for (int k = 1; k <= N; k++) begin
      j = (int'(ptr_i) + k) % N;
      if (!found && req_i[j]) begin
        found      = 1'b1;
        grant_o[j] = 1'b1;
        idx_o      = IW'(j);
      end
    end
  end

  assign valid_o = |req_i;

endmodule

// File: rtl/i2c_arbiter.sv
// rtl/i2c_arbiter.sv - round-robin sharing of one i2c_master among NUM_REQ requesters
module i2c_arbiter
  import i2c_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int TIMEOUT = 65536
) (
  input  logic         clk,
  input  logic         rst,
  i2c_arbiter_if.slave bus
);

  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  arb_state_e            state_q, state_d;
  logic [IW-1:0]         ptr_q, ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [NUM_REQ-1:0]    grant_q, grant_d;
  logic [NUM_REQ-1:0]    done_q, done_d;
  logic [NUM_REQ-1:0]    error_q, error_d;
  logic [I2C_DATA_W-1:0] rd_data_q, rd_data_d;
  logic                  m_en_q, m_en_d;
  logic [I2C_ADDR_W-1:0] m_sa_q, m_sa_d;
  logic                  m_rw_q, m_rw_d;
  logic [I2C_REG_W-1:0]  m_ra_q, m_ra_d;
  logic [I2C_DATA_W-1:0] m_wd_q, m_wd_d;

  logic [NUM_REQ-1:0]    pick_grant;
  logic [IW-1:0]         pick_idx;
  logic                  pick_valid;

  i2c_rr_picker #(
    .N  (NUM_REQ),
    .IW (IW)
  ) u_picker (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .grant_o (pick_grant),
    .idx_o   (pick_idx),
    .valid_o (pick_valid)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= IW'(NUM_REQ - 1);
      cnt_q     <= '0;
      grant_q   <= '0;
      done_q    <= '0;
      error_q   <= '0;
      rd_data_q <= '0;
      m_en_q    <= 1'b0;
      m_sa_q    <= '0;
      m_rw_q    <= 1'b0;
      m_ra_q    <= '0;
      m_wd_q    <= '0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      grant_q   <= grant_d;
      done_q    <= done_d;
      error_q   <= error_d;
      rd_data_q <= rd_data_d;
      m_en_q    <= m_en_d;
      m_sa_q    <= m_sa_d;
      m_rw_q    <= m_rw_d;
      m_ra_q    <= m_ra_d;
      m_wd_q    <= m_wd_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    grant_d   = grant_q;
    done_d    = '0;
    error_d   = '0;
    rd_data_d = rd_data_q;
    m_en_d    = m_en_q;
    m_sa_d    = m_sa_q;
    m_rw_d    = m_rw_q;
    m_ra_d    = m_ra_q;
    m_wd_d    = m_wd_q;

    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_grant;
          ptr_d   = pick_idx;
          cnt_d   = '0;
          m_en_d  = 1'b1;
          m_sa_d  = bus.req_slave_address[int'(pick_idx)*I2C_ADDR_W +: I2C_ADDR_W];
          m_rw_d  = bus.req_read_write[pick_idx];
          m_ra_d  = bus.req_register_address[int'(pick_idx)*I2C_REG_W +: I2C_REG_W];
          m_wd_d  = bus.req_data[int'(pick_idx)*I2C_DATA_W +: I2C_DATA_W];
          state_d = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + 1'b1;
        // Completion is checked first so a pulse on the last allowed cycle still succeeds
        if (bus.m_done) begin
          state_d = S_DONE;
          m_en_d  = 1'b0;
          done_d  = grant_q;
          if (m_rw_q) begin
            rd_data_d = bus.m_data_in;
          end
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
          m_en_d  = 1'b0;
          done_d  = grant_q;
          error_d = grant_q;
        end
      end
      S_DONE: begin
        grant_d = '0;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
        grant_d = '0;
        m_en_d  = 1'b0;
      end
    endcase
  end

  assign bus.grant              = grant_q;
  assign bus.done               = done_q;
  assign bus.error              = error_q;
  assign bus.rd_data            = rd_data_q;
  assign bus.busy               = (state_q != S_IDLE);
  assign bus.m_en               = m_en_q;
  assign bus.m_slave_address    = m_sa_q;
  assign bus.m_read_write       = m_rw_q;
  assign bus.m_register_address = m_ra_q;
  assign bus.m_data             = m_wd_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// tb/tb_i2c_arbiter.sv - scoreboard bench for i2c_arbiter (NUM_REQ=4, TIMEOUT=16)
module tb_i2c_arbiter;
  import i2c_pkg::*;

  localparam int NR = 4;
  localparam int TO = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  i2c_arbiter_if #(.NUM_REQ(NR)) bus ();

  i2c_arbiter #(
    .NUM_REQ (NR),
    .TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [NR-1:0] owner;
    logic          err;
    logic [31:0]   rd;
    logic [6:0]    sa;
    logic          rw;
    logic [7:0]    ra;
    logic [31:0]   wd;
  } exp_t;

  exp_t        exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  logic [31:0] rd_model = '0;
  logic        rr_phase = 1'b0;
  logic        men_prev = 1'b0;
  logic [NR-1:0] done_prev = '0;
  int          low_cnt  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input int i, input logic [6:0] sa, input logic rw, input logic [7:0] ra,
                          input logic [31:0] wd, input logic err, input logic [31:0] rdin);
    exp_t e;
    if (rw && !err) rd_model = rdin;
    e.owner = NR'(1 << i);
    e.err   = err;
    e.rd    = rd_model;
    e.sa    = sa;
    e.rw    = rw;
    e.ra    = ra;
    e.wd    = wd;
    exp_q.push_back(e);
  endtask

  task automatic set_req(input int i, input logic [6:0] sa, input logic rw, input logic [7:0] ra,
                         input logic [31:0] wd);
    bus.req_slave_address[7*i +: 7]     = sa;
    bus.req_read_write[i]               = rw;
    bus.req_register_address[8*i +: 8]  = ra;
    bus.req_data[32*i +: 32]            = wd;
    bus.req[i]                          = 1'b1;
  endtask

  task automatic wait_men(output logic ok);
    ok = 1'b0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (bus.m_en) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check_eq("men_wait", 32'd0, 32'd1);
  endtask

  // Plays the i2c_master: waits for m_en, optionally pulses m_done dly cycles later
  task automatic serve(input int dly, input logic [31:0] rdin, input logic give_done,
                       input logic drop, output int cyc);
    logic ok;
    cyc = 0;
    wait_men(ok);
    if (ok) begin
      if (drop) bus.req = '0;
      repeat (dly) begin
        @(negedge clk);
        cyc++;
      end
      if (give_done) begin
        bus.m_done    = 1'b1;
        bus.m_data_in = rdin;
      end
      ok = 1'b0;
      for (int k = 0; k < 60; k++) begin
        @(negedge clk);
        bus.m_done = 1'b0;
        cyc++;
        if (bus.done != '0) begin
          ok = 1'b1;
          break;
        end
      end
      if (!ok) check_eq("done_wait", 32'd0, 32'd1);
    end
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      men_prev  <= 1'b0;
      done_prev <= '0;
      low_cnt   <= 0;
    end else begin
      if (bus.m_en && !men_prev) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_grant", 32'(bus.grant), 32'd0);
        end else begin
          check_eq("grant", 32'(bus.grant), 32'(exp_q[0].owner));
          check_eq("m_slave_address", 32'(bus.m_slave_address), 32'(exp_q[0].sa));
          check_eq("m_read_write", 32'(bus.m_read_write), 32'(exp_q[0].rw));
          check_eq("m_register_address", 32'(bus.m_register_address), 32'(exp_q[0].ra));
          check_eq("m_data", bus.m_data, exp_q[0].wd);
          check_eq("busy_run", 32'(bus.busy), 32'd1);
        end
        if (rr_phase) check_eq("men_gap", 32'(low_cnt), 32'd2);
      end
      if (bus.done != '0) begin
        if (exp_q.size() == 0) begin
          check_eq("unexpected_done", 32'(bus.done), 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check_eq("done", 32'(bus.done), 32'(e.owner));
          check_eq("error", 32'(bus.error), e.err ? 32'(e.owner) : 32'd0);
          check_eq("rd_data", bus.rd_data, e.rd);
          check_eq("m_en_in_done", 32'(bus.m_en), 32'd0);
        end
      end else if (bus.error != '0) begin
        check_eq("error_without_done", 32'(bus.error), 32'd0);
      end
      if (done_prev != '0) check_eq("done_width", 32'(bus.done), 32'd0);
      low_cnt   <= bus.m_en ? 0 : low_cnt + 1;
      men_prev  <= bus.m_en;
      done_prev <= bus.done;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

  initial begin
    int   cyc;
    logic ok;
    bus.req                  = '0;
    bus.req_slave_address    = '0;
    bus.req_read_write       = '0;
    bus.req_register_address = '0;
    bus.req_data             = '0;
    bus.m_data_in            = '0;
    bus.m_done               = 1'b0;

    repeat (3) @(negedge clk);
    check_eq("rst_grant", 32'(bus.grant), 32'd0);
    check_eq("rst_m_en", 32'(bus.m_en), 32'd0);
    check_eq("rst_busy", 32'(bus.busy), 32'd0);
    check_eq("rst_done", 32'(bus.done), 32'd0);
    check_eq("rst_rd_data", bus.rd_data, 32'd0);
    check_eq("rst_m_slave_address", 32'(bus.m_slave_address), 32'd0);
    rst = 1'b1;
    @(negedge clk);

    // single write, m_data_in carries junk that must not reach rd_data
    push_exp(2, 7'h50, 1'b0, 8'h1A, 32'hDEADBEEF, 1'b0, 32'h0);
    set_req(2, 7'h50, 1'b0, 8'h1A, 32'hDEADBEEF);
    serve(3, 32'h12345678, 1'b1, 1'b0, cyc);
    bus.req[2] = 1'b0;

    push_exp(1, 7'h3C, 1'b1, 8'h05, 32'h0, 1'b0, 32'hA5A50F0F);
    set_req(1, 7'h3C, 1'b1, 8'h05, 32'h0);
    serve(4, 32'hA5A50F0F, 1'b1, 1'b0, cyc);
    bus.req[1] = 1'b0;

    // watchdog expiry, and m_done landing on the final RUN cycle
    push_exp(3, 7'h21, 1'b0, 8'hF0, 32'h11112222, 1'b1, 32'h0);
    set_req(3, 7'h21, 1'b0, 8'hF0, 32'h11112222);
    serve(0, 32'hFFFFFFFF, 1'b0, 1'b0, cyc);
    check_eq("timeout_cycles", 32'(cyc), 32'(TO));
    bus.req[3] = 1'b0;

    push_exp(3, 7'h22, 1'b1, 8'hF1, 32'h0, 1'b0, 32'h0BADF00D);
    set_req(3, 7'h22, 1'b1, 8'hF1, 32'h0);
    serve(TO - 1, 32'h0BADF00D, 1'b1, 1'b0, cyc);
    check_eq("last_cycle_done_cycles", 32'(cyc), 32'(TO));
    bus.req[3] = 1'b0;

    for (int k = 0; k < 5; k++)
      push_exp(k % NR, 7'(7'h40 + k % NR), 1'b0, 8'(8'h10 + k % NR), 32'hC0DE0000 + 32'(k % NR),
               1'b0, 32'h0);
    for (int i = 0; i < NR; i++)
      set_req(i, 7'(7'h40 + i), 1'b0, 8'(8'h10 + i), 32'hC0DE0000 + 32'(i));
    for (int k = 0; k < 5; k++) begin
      serve(9, 32'h0, 1'b1, 1'b0, cyc);
      if (k == 0) rr_phase = 1'b1;
      if (k == 4) bus.req = '0;
    end
    rr_phase = 1'b0;

    // stray m_done while idle
    @(negedge clk);
    bus.m_done = 1'b1;
    @(negedge clk);
    bus.m_done = 1'b0;
    check_eq("stray_busy", 32'(bus.busy), 32'd0);
    check_eq("stray_m_en", 32'(bus.m_en), 32'd0);
    repeat (2) @(negedge clk);
    check_eq("stray_busy_later", 32'(bus.busy), 32'd0);

    push_exp(0, 7'h11, 1'b1, 8'h22, 32'h0, 1'b0, 32'h600DCAFE);
    set_req(0, 7'h11, 1'b1, 8'h22, 32'h0);
    serve(5, 32'h600DCAFE, 1'b1, 1'b1, cyc);

    // asynchronous reset in the middle of RUN
    push_exp(1, 7'h33, 1'b0, 8'h44, 32'h55667788, 1'b0, 32'h0);
    set_req(1, 7'h33, 1'b0, 8'h44, 32'h55667788);
    wait_men(ok);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check_eq("async_rst_m_en", 32'(bus.m_en), 32'd0);
    check_eq("async_rst_grant", 32'(bus.grant), 32'd0);
    check_eq("async_rst_busy", 32'(bus.busy), 32'd0);
    check_eq("async_rst_rd_data", bus.rd_data, 32'd0);
    exp_q.delete();
    rd_model = '0;
    bus.req  = '0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    push_exp(0, 7'h01, 1'b0, 8'h02, 32'h03040506, 1'b0, 32'h0);
    push_exp(1, 7'h07, 1'b1, 8'h08, 32'h0, 1'b0, 32'h9ABCDEF0);
    set_req(0, 7'h01, 1'b0, 8'h02, 32'h03040506);
    set_req(1, 7'h07, 1'b1, 8'h08, 32'h0);
    serve(2, 32'h0, 1'b1, 1'b0, cyc);
    bus.req[0] = 1'b0;
    serve(2, 32'h9ABCDEF0, 1'b1, 1'b0, cyc);
    bus.req[1] = 1'b0;

    repeat (4) @(negedge clk);
    check_eq("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    check_eq("final_busy", 32'(bus.busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
